// File: rtl/cu_int_sequencer_if.sv
// Bus between the interrupt-entry sequencer and the CU FSM / datapath / capture flops.
// The slave side is the sequencer; the master side is everything around it.
interface cu_int_sequencer_if;
  logic        CU_RstReq;
  logic        CU_bNMI_Flg;
  logic        CU_bIRQ_Flg;
  logic        CU_IFlag;
  logic        CU_InstEnd;
  logic        CU_BrkDec;
  logic        CU_Rdy;
  logic [7:0]  CU_SP;
  logic [15:0] CU_SeqAddr;
  logic        CU_SeqRW;
  logic [1:0]  CU_SeqDSel;
  logic        CU_SeqBFlg;
  logic        CU_SpDec;
  logic        CU_PclLd;
  logic        CU_PchLd;
  logic        CU_SetI;
  logic        CU_IntBusy;
  logic        CU_IntDone;
  logic        bnmi_sd;
  logic        birq_sd;

  modport master (
    output CU_RstReq, CU_bNMI_Flg, CU_bIRQ_Flg, CU_IFlag, CU_InstEnd, CU_BrkDec,
    output CU_Rdy, CU_SP,
    input  CU_SeqAddr, CU_SeqRW, CU_SeqDSel, CU_SeqBFlg, CU_SpDec, CU_PclLd,
    input  CU_PchLd, CU_SetI, CU_IntBusy, CU_IntDone, bnmi_sd, birq_sd
  );

  modport slave (
    input  CU_RstReq, CU_bNMI_Flg, CU_bIRQ_Flg, CU_IFlag, CU_InstEnd, CU_BrkDec,
    input  CU_Rdy, CU_SP,
    output CU_SeqAddr, CU_SeqRW, CU_SeqDSel, CU_SeqBFlg, CU_SpDec, CU_PclLd,
    output CU_PchLd, CU_SetI, CU_IntBusy, CU_IntDone, bnmi_sd, birq_sd
  );
endinterface

// File: rtl/cu_int_sequencer.sv
// 6502 interrupt entry sequencer (RST/NMI/IRQ/BRK): arbitration, 7-cycle push/vector
// sequence, and active-low clear strobes back to the interrupt-capture flops.
module cu_int_sequencer #(
  parameter logic [15:0] NMI_VEC = 16'hFFFA,
  parameter logic [15:0] RST_VEC = 16'hFFFC,
  parameter logic [15:0] IRQ_VEC = 16'hFFFE
) (
  input  logic              CU_Clk,
  input  logic              CU_Rst,
  cu_int_sequencer_if.slave bus
);

  typedef enum logic [2:0] {
    S_IDLE, S_D1, S_D2, S_PUSH_H, S_PUSH_L, S_PUSH_P, S_VEC_L, S_VEC_H
  } state_t;

  typedef enum logic [1:0] {SRC_RST, SRC_NMI, SRC_IRQ, SRC_BRK} src_t;

  localparam state_t S_RST_D1 = S_D1;

  state_t      r_state;
  src_t        r_src;
  logic [15:0] r_vec;
  logic [15:0] r_seq_addr;
  logic        r_seq_rw;
  logic [1:0]  r_seq_dsel;
  logic        r_seq_bflg;
  logic        r_sp_dec;
  logic        r_pcl_ld;
  logic        r_pch_ld;
  logic        r_set_i;
  logic        r_int_busy;
  logic        r_int_done;
  logic        r_bnmi_sd;
  logic        r_birq_sd;

  state_t      w_nxt_state;
  src_t        w_nxt_src;
  logic [15:0] w_nxt_vec;
  logic        w_stall;
  logic [7:0]  w_sp_eff;

  function automatic logic [15:0] f_src_vec(input src_t src);
    logic [15:0] vec;
    case (src)
      SRC_RST: vec = RST_VEC;
      SRC_NMI: vec = NMI_VEC;
      default: vec = IRQ_VEC;
    endcase
    return vec;
  endfunction

  // The datapath applies a pending SP decrement on the same edge that registers the
  // next push address, so anticipate it here.
  assign w_sp_eff = bus.CU_SP - {7'd0, r_sp_dec};

  // Next state, source and vector selection.
  always_comb begin
    w_nxt_state = r_state;
    w_nxt_src   = r_src;
    w_nxt_vec   = r_vec;
    w_stall     = 1'b0;
    if (bus.CU_RstReq) begin
      w_nxt_state = S_D1;
      w_nxt_src   = SRC_RST;
    end else if (!bus.CU_Rdy) begin
      w_stall = 1'b1;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (bus.CU_InstEnd && bus.CU_bNMI_Flg) begin
            w_nxt_state = S_D1;
            w_nxt_src   = SRC_NMI;
          end else if (bus.CU_InstEnd && bus.CU_bIRQ_Flg && !bus.CU_IFlag) begin
            w_nxt_state = S_D1;
            w_nxt_src   = SRC_IRQ;
          end else if (bus.CU_InstEnd && bus.CU_BrkDec) begin
            w_nxt_state = S_D1;
            w_nxt_src   = SRC_BRK;
          end else begin
            w_nxt_state = S_IDLE;
          end
        end
        S_D1:     w_nxt_state = S_D2;
        S_D2:     w_nxt_state = S_PUSH_H;
        S_PUSH_H: w_nxt_state = S_PUSH_L;
        S_PUSH_L: w_nxt_state = S_PUSH_P;
        S_PUSH_P: begin
          w_nxt_state = S_VEC_L;
          // A late NMI hijacks IRQ/BRK entry; reset entry is never redirected.
          if (bus.CU_bNMI_Flg && (r_src != SRC_RST)) begin
            w_nxt_vec = NMI_VEC;
          end else begin
            w_nxt_vec = f_src_vec(r_src);
          end
        end
        S_VEC_L:  w_nxt_state = S_VEC_H;
        S_VEC_H:  w_nxt_state = S_IDLE;
        default:  w_nxt_state = S_IDLE;
      endcase
    end
  end

  // State register plus outputs registered from the state being entered.
  // Strobes fire on entry to a state; a stall repeats the state with strobes quiet.
  always_ff @(posedge CU_Clk) begin
    if (CU_Rst) begin
      r_state    <= S_RST_D1;
      r_src      <= SRC_RST;
      r_vec      <= RST_VEC;
      r_seq_addr <= 16'h0000;
      r_seq_rw   <= 1'b1;
      r_seq_dsel <= 2'd0;
      r_seq_bflg <= 1'b0;
      r_sp_dec   <= 1'b0;
      r_pcl_ld   <= 1'b0;
      r_pch_ld   <= 1'b0;
      r_set_i    <= 1'b0;
      r_int_busy <= 1'b1;
      r_int_done <= 1'b0;
      r_bnmi_sd  <= 1'b1;
      r_birq_sd  <= 1'b1;
    end else begin
      r_state    <= w_nxt_state;
      r_src      <= w_nxt_src;
      r_vec      <= w_nxt_vec;
      r_sp_dec   <= 1'b0;
      r_pcl_ld   <= 1'b0;
      r_pch_ld   <= 1'b0;
      r_set_i    <= 1'b0;
      r_int_done <= 1'b0;
      r_bnmi_sd  <= 1'b1;
      r_birq_sd  <= 1'b1;
      if (!w_stall) begin
        r_seq_addr <= 16'h0000;
        r_seq_rw   <= 1'b1;
        r_seq_dsel <= 2'd0;
        r_seq_bflg <= 1'b0;
        r_int_busy <= (w_nxt_state != S_IDLE);
        case (w_nxt_state)
          S_PUSH_H: begin
            r_seq_addr <= {8'h01, w_sp_eff};
            r_seq_rw   <= (w_nxt_src == SRC_RST);
            r_seq_dsel <= (w_nxt_src == SRC_RST) ? 2'd0 : 2'd1;
            r_sp_dec   <= 1'b1;
          end
          S_PUSH_L: begin
            r_seq_addr <= {8'h01, w_sp_eff};
            r_seq_rw   <= (w_nxt_src == SRC_RST);
            r_seq_dsel <= (w_nxt_src == SRC_RST) ? 2'd0 : 2'd2;
            r_sp_dec   <= 1'b1;
          end
          S_PUSH_P: begin
            r_seq_addr <= {8'h01, w_sp_eff};
            r_seq_rw   <= (w_nxt_src == SRC_RST);
            r_seq_dsel <= (w_nxt_src == SRC_RST) ? 2'd0 : 2'd3;
            r_seq_bflg <= (w_nxt_src == SRC_BRK);
            r_sp_dec   <= 1'b1;
          end
          S_VEC_L: begin
            r_seq_addr <= w_nxt_vec;
            r_pcl_ld   <= 1'b1;
            r_set_i    <= 1'b1;
            r_bnmi_sd  <= (w_nxt_vec != NMI_VEC);
            r_birq_sd  <= !((w_nxt_src == SRC_IRQ) && (w_nxt_vec == IRQ_VEC));
          end
          S_VEC_H: begin
            r_seq_addr <= w_nxt_vec + 16'd1;
            r_pch_ld   <= 1'b1;
            r_int_done <= 1'b1;
          end
          default: begin
            r_seq_addr <= 16'h0000;
          end
        endcase
      end
    end
  end

  assign bus.CU_SeqAddr = r_seq_addr;
  assign bus.CU_SeqRW   = r_seq_rw;
  assign bus.CU_SeqDSel = r_seq_dsel;
  assign bus.CU_SeqBFlg = r_seq_bflg;
  assign bus.CU_SpDec   = r_sp_dec;
  assign bus.CU_PclLd   = r_pcl_ld;
  assign bus.CU_PchLd   = r_pch_ld;
  assign bus.CU_SetI    = r_set_i;
  assign bus.CU_IntBusy = r_int_busy;
  assign bus.CU_IntDone = r_int_done;
  assign bus.bnmi_sd    = r_bnmi_sd;
  assign bus.birq_sd    = r_birq_sd;

endmodule

// File: tb/tb_cu_int_sequencer.sv
// Scoreboard bench for cu_int_sequencer: stimulus queues expected bus cycles and
// IntDone cycle numbers; a negedge monitor compares every cycle the DUT presents.
module tb_cu_int_sequencer;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  cu_int_sequencer_if bus();

  cu_int_sequencer dut (
    .CU_Clk (clk),
    .CU_Rst (rst),
    .bus    (bus)
  );

  int unsigned total = 0;
  int unsigned bad = 0;
  int unsigned cyc_cnt = 0;
  logic [7:0]  sp_base = 8'h00;
  logic [7:0]  sp_decs = 8'h00;
  logic [26:0] exp_q[$];
  int unsigned done_q[$];
  logic        fin_req = 1'b0;
  logic        fin_done = 1'b0;

  // {addr, rw, dsel, bflg, spdec, pclld, pchld, seti, done, bnmi_sd, birq_sd}
  localparam logic [26:0] QUIET = {16'h0000, 1'b1, 2'd0, 1'b0, 5'd0, 2'b11};

  // Datapath stand-in: SP follows the sequencer's decrement strobe.
  assign bus.CU_SP = sp_base - sp_decs;
  always @(posedge clk) if (bus.CU_SpDec) sp_decs <= sp_decs + 8'd1;
  always @(posedge clk) cyc_cnt <= cyc_cnt + 1;

  function automatic logic [26:0] rec(input logic [15:0] a, input logic rw,
      input logic [1:0] ds, input logic b, input logic spd, input logic pcl,
      input logic pch, input logic si, input logic dn, input logic nsd, input logic isd);
    return {a, rw, ds, b, spd, pcl, pch, si, dn, nsd, isd};
  endfunction

  task automatic chk(input string nm, input logic [26:0] a, input logic [26:0] e);
    total++;
    if (a !== e) begin
      bad++;
      $display("FAIL %s got=%h exp=%h (cycle %0d)", nm, a, e, cyc_cnt);
    end
  endtask

  // Monitor: every cycle is either an expected sequence cycle or fully quiet.
  always @(negedge clk) begin
    logic [26:0] act;
    int unsigned exp_c;
    act = {bus.CU_SeqAddr, bus.CU_SeqRW, bus.CU_SeqDSel, bus.CU_SeqBFlg, bus.CU_SpDec,
           bus.CU_PclLd, bus.CU_PchLd, bus.CU_SetI, bus.CU_IntDone, bus.bnmi_sd, bus.birq_sd};
    if (rst) begin
      chk("reset_out", act, QUIET);
    end else if (bus.CU_IntBusy) begin
      if (exp_q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL unexpected_busy got=%h exp=idle", act);
      end else begin
        chk("seq_cycle", act, exp_q.pop_front());
      end
    end else begin
      chk("idle_out", act, QUIET);
    end
    if (!rst && bus.CU_IntDone) begin
      total++;
      if (done_q.size() == 0) begin
        bad++;
        $display("FAIL done_cycle got=%0d exp=none", cyc_cnt);
      end else begin
        exp_c = done_q.pop_front();
        if (cyc_cnt != exp_c) begin
          bad++;
          $display("FAIL done_cycle got=%0d exp=%0d", cyc_cnt, exp_c);
        end
      end
    end
    if (fin_req && !fin_done) begin
      total += 2;
      if (exp_q.size() != 0) begin
        bad++;
        $display("FAIL exp_left got=%0d exp=0", exp_q.size());
      end
      if (done_q.size() != 0) begin
        bad++;
        $display("FAIL done_left got=%0d exp=0", done_q.size());
      end
      fin_done = 1'b1;
    end
  end

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic set_sp(input logic [7:0] v);
    sp_base = v + sp_decs;
  endtask

  // Expected bus cycles of one entry sequence starting at SP=s; stall_n extra PUSH_L cycles.
  task automatic exp_seq(input logic rs, input logic [7:0] s, input logic [15:0] v,
      input logic b, input logic nclr, input logic iclr, input int stall_n);
    exp_q.push_back(QUIET);
    exp_q.push_back(QUIET);
    exp_q.push_back(rec({8'h01, s}, rs, rs ? 2'd0 : 2'd1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1));
    exp_q.push_back(rec({8'h01, s - 8'd1}, rs, rs ? 2'd0 : 2'd2, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1));
    for (int i = 0; i < stall_n; i++)
      exp_q.push_back(rec({8'h01, s - 8'd1}, rs, rs ? 2'd0 : 2'd2, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1));
    exp_q.push_back(rec({8'h01, s - 8'd2}, rs, rs ? 2'd0 : 2'd3, b, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1));
    exp_q.push_back(rec(v, 1'b1, 2'd0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, ~nclr, ~iclr));
    exp_q.push_back(rec(v + 16'd1, 1'b1, 2'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1));
  endtask

  // One-cycle InstEnd (BrkDec alongside); lat>0 queues the expected IntDone cycle.
  task automatic inst_end(input logic brk, input int unsigned lat);
    @(posedge clk);
    #1;
    bus.CU_InstEnd = 1'b1;
    bus.CU_BrkDec  = brk;
    if (lat != 0) done_q.push_back(cyc_cnt + lat);
    @(posedge clk);
    #1;
    bus.CU_InstEnd = 1'b0;
    bus.CU_BrkDec  = 1'b0;
  endtask

  task automatic wait_done();
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (bus.CU_IntDone) break;
    end
    tick(1);
  endtask

  initial begin
    rst             = 1'b1;
    bus.CU_RstReq   = 1'b0;
    bus.CU_bNMI_Flg = 1'b0;
    bus.CU_bIRQ_Flg = 1'b0;
    bus.CU_IFlag    = 1'b0;
    bus.CU_InstEnd  = 1'b0;
    bus.CU_BrkDec   = 1'b0;
    bus.CU_Rdy      = 1'b1;
    set_sp(8'hFD);
    tick(3);

    // Reset release: dummy pushes at 01FD/01FC/01FB, vector FFFC, done in 7th cycle.
    exp_seq(1'b1, 8'hFD, 16'hFFFC, 1'b0, 1'b0, 1'b0, 0);
    done_q.push_back(cyc_cnt + 32'd6);
    rst = 1'b0;
    wait_done();

    // IRQ entry, SP=FF.
    set_sp(8'hFF);
    bus.CU_bIRQ_Flg = 1'b1;
    exp_seq(1'b0, 8'hFF, 16'hFFFE, 1'b0, 1'b0, 1'b1, 0);
    inst_end(1'b0, 7);
    wait_done();

    // Masked IRQ without BRK stays idle; BRK then runs with B=1 and no IRQ clear.
    bus.CU_IFlag = 1'b1;
    inst_end(1'b0, 0);
    tick(3);
    set_sp(8'hF0);
    exp_seq(1'b0, 8'hF0, 16'hFFFE, 1'b1, 1'b0, 1'b0, 0);
    inst_end(1'b1, 7);
    wait_done();
    bus.CU_bIRQ_Flg = 1'b0;

    // BRK hijacked by NMI rising during PUSH_L.
    set_sp(8'h40);
    exp_seq(1'b0, 8'h40, 16'hFFFA, 1'b1, 1'b1, 1'b0, 0);
    inst_end(1'b1, 7);
    tick(3);
    bus.CU_bNMI_Flg = 1'b1;
    wait_done();
    bus.CU_bNMI_Flg = 1'b0;

    // NMI and IRQ together, SP=00 wraps: NMI first, retained IRQ at the next InstEnd.
    bus.CU_IFlag    = 1'b0;
    bus.CU_bNMI_Flg = 1'b1;
    bus.CU_bIRQ_Flg = 1'b1;
    set_sp(8'h00);
    exp_seq(1'b0, 8'h00, 16'hFFFA, 1'b0, 1'b1, 1'b0, 0);
    inst_end(1'b0, 7);
    wait_done();
    bus.CU_bNMI_Flg = 1'b0;
    tick(2);
    exp_seq(1'b0, 8'hFD, 16'hFFFE, 1'b0, 1'b0, 1'b1, 0);
    inst_end(1'b0, 7);
    wait_done();

    // Rdy low for three cycles in PUSH_L: one SpDec, done after 10 cycles.
    set_sp(8'hC0);
    exp_seq(1'b0, 8'hC0, 16'hFFFE, 1'b0, 1'b0, 1'b1, 3);
    inst_end(1'b0, 10);
    tick(3);
    bus.CU_Rdy = 1'b0;
    tick(3);
    bus.CU_Rdy = 1'b1;
    wait_done();

    // RstReq during PUSH_H restarts as a reset sequence.
    set_sp(8'h80);
    exp_q.push_back(QUIET);
    exp_q.push_back(QUIET);
    exp_q.push_back(rec(16'h0180, 1'b0, 2'd1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1));
    exp_seq(1'b1, 8'h7F, 16'hFFFC, 1'b0, 1'b0, 1'b0, 0);
    inst_end(1'b0, 10);
    tick(2);
    bus.CU_RstReq = 1'b1;
    tick(1);
    bus.CU_RstReq = 1'b0;
    wait_done();
    bus.CU_bIRQ_Flg = 1'b0;

    tick(2);
    fin_req = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      if (fin_done) break;
    end
    #1;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
